pis_serializer_mc: RTL and testbench
====================================

# pis_serializer_mc

Parametrised multi-channel parallel-in/serial-out serializer for pixel-column route data. It sits between the column readout logic, with N_CH columns each presenting a DATA_W-bit routed word, and the single-bit peripheral output link. Round-robin arbitration picks a column, captures its word, acknowledges it, and shifts it out MSB-first with a frame-start strobe and channel tag. Idle-time shake-hands forwarding to the columns is kept, now per channel.

## Interface
Parameters:
- DATA_W, 28, route word width (≥2)
- N_CH, 4, number of column channels (≥2)
- CH_W, 2, channel-ID width, = ceil(log2(N_CH))

Ports:
- clk_40MHz  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- route_data_in  input  N_CH*DATA_W  channel i word at bits [i*DATA_W +: DATA_W]; nonzero word = request
- shake_hands_spi  input  1  global shake-hands from SPI side
- shake_hands_in  input  N_CH  per-channel shake-hands from output side
- shake_hands_col  output  N_CH  registered shake-hands forwarded to columns
- ack_col  output  N_CH  one-hot, one-cycle pulse: word of channel i captured
- serial_out  output  1  serial data bit (shift-register MSB)
- valid_out  output  1  one-cycle pulse coincident with first bit of a frame
- ch_id_out  output  CH_W  channel of current frame, held for the whole frame
- busy  output  1  high while a frame is being shifted

## Operation
- FRAME_LEN = DATA_W (DATA_W+1 with parity, see Configuration); bit counter cnt, width ceil(log2(FRAME_LEN)), range 0..FRAME_LEN-1.
- Slot-decision state: cnt == FRAME_LEN-1. Reset places the block here.
- In the decision state:
  - If any request is present, grant the first requesting channel at or after rr_ptr (wrapping N_CH-1→0).
  - On a grant: load shreg with the word (MSB at serial_out), ch_id_out=grant, valid_out=1, ack_col[grant]=1, shake_hands_col=0 (all bits), cnt=0, busy=1, rr_ptr=grant+1 mod N_CH.
  - If no request: shreg=0, valid_out=0, busy=0, cnt stays FRAME_LEN-1, shake_hands_col[i]=shake_hands_spi|shake_hands_in[i].
- Shift state (cnt < FRAME_LEN-1): rotate shreg left by 1, cnt+1, valid_out=0, ack_col=0, shake_hands_col=0. busy stays 1 until the cycle after the last bit, unless a new grant occurs.
- Back-to-back: the last bit cycle is itself a decision cycle. A pending request loads on the next edge with zero gap, so frame period = FRAME_LEN cycles.
- Requests are sampled only in decision cycles. Word changes mid-frame are ignored; a word that goes to zero before its decision cycle is never served.
- Round-robin guarantees that no channel waits more than N_CH frames while requesting.

## Timing
- Reset values (registered, first edge with rst=1): serial_out=0, valid_out=0, ack_col=0, ch_id_out=0, busy=0, shake_hands_col=0, cnt=FRAME_LEN-1, rr_ptr=0, shreg=0.
- Latency: request visible at decision-cycle edge → valid_out, first bit, and ack_col on the outputs after that edge (1 cycle).
- Bit k (0 = MSB) of the frame is on serial_out k cycles after valid_out.
- ack_col precedes upstream clearing. The upstream must clear or replace the word before the next decision cycle (≥ FRAME_LEN-1 cycles later), or the word is serialized again.
- rst mid-frame aborts the frame at once: no further bits and no valid_out; outputs take reset values on that edge.
- rst wins over a simultaneous request.

## Configuration
- PIS_PARITY_EN defined: FRAME_LEN = DATA_W+1. After the data LSB, one extra bit = XOR of the captured word (even parity over data+parity). Parity is computed at capture and appended as shreg LSB.
- Not defined: FRAME_LEN = DATA_W, no parity logic present.

## Test plan
- Reset: assert rst 3 cycles with all channels requesting → all outputs 0, cnt = FRAME_LEN-1. Release → channel 0 granted first.
- Single word: DATA_W=28, ch2 = 28'h8000001, others 0 → valid_out 1 cycle, ch_id_out=2, ack_col=4'b0100, serial_out=1, then 26×0, then 1. busy low the cycle after the last bit.
- Round-robin: all four channels requesting continuously → grants 0,1,2,3,0, each frame exactly 28 cycles apart with no idle gap.
- Idle forwarding: no requests, shake_hands_spi=0, shake_hands_in=4'b1010 → shake_hands_col=4'b1010 next cycle. During any frame → 4'b0000.
- Mid-frame reset: assert rst at bit 10 of a frame → serial_out=0, busy=0, no further valid_out until a new request.
- PIS_PARITY_EN: word 28'h0000007 → 29-bit frame, final bit = 1. With word 28'h0000003 → final bit = 0.

Source files
------------

// File: rtl/pis_serializer_mc.sv
// Multi-channel round-robin parallel-in/serial-out serializer for pixel-column route words.
// Optional build macro PIS_PARITY_EN appends an even-parity bit after the data LSB.
module pis_serializer_mc #(
    parameter int DATA_W = 28,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2
) (
    input  logic                     clk_40MHz,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   route_data_in,
    input  logic                     shake_hands_spi,
    input  logic [N_CH-1:0]          shake_hands_in,
    output logic [N_CH-1:0]          shake_hands_col,
    output logic [N_CH-1:0]          ack_col,
    output logic                     serial_out,
    output logic                     valid_out,
    output logic [CH_W-1:0]          ch_id_out,
    output logic                     busy
);

`ifdef PIS_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

`ifdef PIS_PARITY_EN
    function automatic logic word_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    logic [CNT_W-1:0]     cnt_r;
    logic [FRAME_LEN-1:0] shreg_r;
    logic [CH_W-1:0]      rr_ptr_r;

    logic [N_CH-1:0]      req_s;
    logic [CH_W-1:0]      grant_s;
    logic                 grant_valid_s;
    logic [DATA_W-1:0]    sel_word_s;
    logic [FRAME_LEN-1:0] load_word_s;

    logic [CNT_W-1:0]     cnt_n;
    logic [FRAME_LEN-1:0] shreg_n;
    logic [CH_W-1:0]      rr_ptr_n;
    logic [CH_W-1:0]      ch_id_n;
    logic                 valid_n;
    logic                 busy_n;
    logic [N_CH-1:0]      ack_n;
    logic [N_CH-1:0]      shc_n;

    // Per-channel request: any nonzero word is a request.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_s[i] = |route_data_in[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [CH_W:0] idx;
        idx           = '0;
        grant_s       = '0;
        grant_valid_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, rr_ptr_r} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end else begin
                idx = idx;
            end
            if (!grant_valid_s && req_s[idx[CH_W-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_s       = idx[CH_W-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    assign sel_word_s = route_data_in[grant_s*DATA_W +: DATA_W];
`ifdef PIS_PARITY_EN
    assign load_word_s = {sel_word_s, word_parity(sel_word_s)};
`else
    assign load_word_s = sel_word_s;
`endif

    // Next-state: decision slot at cnt == FRAME_LEN-1, otherwise shift.
    always_comb begin
        cnt_n    = cnt_r;
        shreg_n  = shreg_r;
        rr_ptr_n = rr_ptr_r;
        ch_id_n  = ch_id_out;
        valid_n  = 1'b0;
        busy_n   = busy;
        ack_n    = '0;
        shc_n    = '0;
        if (cnt_r == CNT_LAST) begin
            if (grant_valid_s) begin
                shreg_n = load_word_s;
                ch_id_n = grant_s;
                valid_n = 1'b1;
                ack_n   = N_CH'(1'b1) << grant_s;
                cnt_n   = '0;
                busy_n  = 1'b1;
                if (grant_s == CH_W'(N_CH - 1)) begin
                    rr_ptr_n = '0;
                end else begin
                    rr_ptr_n = grant_s + CH_W'(1);
                end
            end else begin
                shreg_n = '0;
                busy_n  = 1'b0;
                shc_n   = {N_CH{shake_hands_spi}} | shake_hands_in;
            end
        end else begin
            shreg_n = {shreg_r[FRAME_LEN-2:0], shreg_r[FRAME_LEN-1]};
            cnt_n   = cnt_r + CNT_W'(1);
            busy_n  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            cnt_r           <= CNT_LAST;
            shreg_r         <= '0;
            rr_ptr_r        <= '0;
            ch_id_out       <= '0;
            valid_out       <= 1'b0;
            busy            <= 1'b0;
            ack_col         <= '0;
            shake_hands_col <= '0;
        end else begin
            cnt_r           <= cnt_n;
            shreg_r         <= shreg_n;
            rr_ptr_r        <= rr_ptr_n;
            ch_id_out       <= ch_id_n;
            valid_out       <= valid_n;
            busy            <= busy_n;
            ack_col         <= ack_n;
            shake_hands_col <= shc_n;
        end
    end

    assign serial_out = shreg_r[FRAME_LEN-1];

endmodule

// File: tb/tb_pis_serializer_mc.sv
// Directed self-checking bench for pis_serializer_mc (DATA_W=28, N_CH=4); honours PIS_PARITY_EN.
module tb_pis_serializer_mc;
    localparam int DATA_W = 28;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;
`ifdef PIS_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif

    logic                   clk_40MHz = 1'b0;
    logic                   rst = 1'b1;
    logic [N_CH*DATA_W-1:0] route_data_in = '0;
    logic                   shake_hands_spi = 1'b0;
    logic [N_CH-1:0]        shake_hands_in = '0;
    logic [N_CH-1:0]        shake_hands_col;
    logic [N_CH-1:0]        ack_col;
    logic                   serial_out;
    logic                   valid_out;
    logic [CH_W-1:0]        ch_id_out;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] words [N_CH] = '{28'hA5A5A5A, 28'h1234567, 28'h8000001, 28'hFFFFFFF};

    pis_serializer_mc #(.DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk_40MHz      (clk_40MHz),
        .rst            (rst),
        .route_data_in  (route_data_in),
        .shake_hands_spi(shake_hands_spi),
        .shake_hands_in (shake_hands_in),
        .shake_hands_col(shake_hands_col),
        .ack_col        (ack_col),
        .serial_out     (serial_out),
        .valid_out      (valid_out),
        .ch_id_out      (ch_id_out),
        .busy           (busy)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_40MHz);
        #1;
    endtask

    function automatic logic [FL-1:0] frame_of(input logic [DATA_W-1:0] w);
`ifdef PIS_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic expect_start(input string tag, input int ch, input logic [DATA_W-1:0] w);
        logic [FL-1:0] f;
        f = frame_of(w);
        check({tag, "_valid"}, 64'(valid_out), 64'd1);
        check({tag, "_chid"},  64'(ch_id_out), 64'(ch));
        check({tag, "_ack"},   64'(ack_col), 64'(4'b0001 << ch));
        check({tag, "_busy"},  64'(busy), 64'd1);
        check({tag, "_bit0"},  64'(serial_out), 64'(f[FL-1]));
        check({tag, "_shc"},   64'(shake_hands_col), 64'd0);
    endtask

    // Steps through bits 1..upto of the frame for word w.
    task automatic expect_body(input string tag, input int ch, input logic [DATA_W-1:0] w, input int upto);
        logic [FL-1:0] f;
        f = frame_of(w);
        for (int k = 1; k <= upto; k++) begin
            step();
            check({tag, "_bit"}, 64'(serial_out), 64'(f[FL-1-k]));
            check({tag, "_novalid"}, 64'(valid_out), 64'd0);
            if (k == 1) begin
                check({tag, "_ack0"},  64'(ack_col), 64'd0);
                check({tag, "_chheld"}, 64'(ch_id_out), 64'(ch));
                check({tag, "_shc0"},  64'(shake_hands_col), 64'd0);
                check({tag, "_busy"},  64'(busy), 64'd1);
            end
        end
    endtask

    task automatic set_word(input int ch, input logic [DATA_W-1:0] w);
        route_data_in[ch*DATA_W +: DATA_W] = w;
    endtask

    initial begin
        // Reset with every channel requesting and shake-hands active.
        for (int i = 0; i < N_CH; i++) set_word(i, words[i]);
        shake_hands_spi = 1'b1;
        shake_hands_in  = 4'b1111;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_valid", 64'(valid_out), 64'd0);
            check("rst_serial", 64'(serial_out), 64'd0);
            check("rst_ack", 64'(ack_col), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_chid", 64'(ch_id_out), 64'd0);
            check("rst_shc", 64'(shake_hands_col), 64'd0);
        end
        check("rst_cnt", 64'(dut.cnt_r), 64'(FL - 1));

        // Round-robin with all four channels requesting: 0,1,2,3,0 back-to-back.
        shake_hands_spi = 1'b0;
        shake_hands_in  = 4'b1010;
        rst = 1'b0;
        for (int fr = 0; fr < 5; fr++) begin
            if (fr == 4) begin
                for (int i = 0; i < N_CH; i++) set_word(i, '0);
                set_word(0, words[0]);
            end
            step();
            expect_start("rr_start", fr % N_CH, words[fr % N_CH]);
            if (fr == 4) set_word(0, '0);
            expect_body("rr_body", fr % N_CH, words[fr % N_CH], FL - 1);
        end

        // Idle: no requests, shake-hands forwarded.
        step();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(valid_out), 64'd0);
        check("idle_serial", 64'(serial_out), 64'd0);
        check("idle_shc_in", 64'(shake_hands_col), 64'(4'b1010));
        shake_hands_spi = 1'b1;
        step();
        check("idle_shc_spi", 64'(shake_hands_col), 64'(4'b1111));
        shake_hands_spi = 1'b0;
        shake_hands_in  = 4'b0000;
        step();
        check("idle_shc_off", 64'(shake_hands_col), 64'd0);

        // Single word on channel 2; upstream clears after ack.
        set_word(2, 28'h8000001);
        step();
        expect_start("single_start", 2, 28'h8000001);
        set_word(2, '0);
        expect_body("single_body", 2, 28'h8000001, FL - 1);
        step();
        check("single_busy_end", 64'(busy), 64'd0);
        check("single_valid_end", 64'(valid_out), 64'd0);
        check("single_serial_end", 64'(serial_out), 64'd0);

        // Channel 1 after pointer moved to 3 (wrap); reset at bit 10.
        set_word(1, 28'h7FFFFFF);
        step();
        expect_start("wrap_start", 1, 28'h7FFFFFF);
        set_word(1, '0);
        expect_body("wrap_body", 1, 28'h7FFFFFF, 10);
        rst = 1'b1;
        step();
        check("midrst_serial", 64'(serial_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_chid", 64'(ch_id_out), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < FL + 2; c++) begin
            step();
            check("postrst_valid", 64'(valid_out), 64'd0);
            check("postrst_serial", 64'(serial_out), 64'd0);
            check("postrst_busy", 64'(busy), 64'd0);
        end

        // Only channel 3 requesting after reset.
        set_word(3, 28'h0000005);
        step();
        expect_start("ch3_start", 3, 28'h0000005);
        set_word(3, '0);
        expect_body("ch3_body", 3, 28'h0000005, FL - 1);

`ifdef PIS_PARITY_EN
        // Parity bit: odd-weight word -> 1, even-weight word -> 0.
        set_word(0, 28'h0000007);
        step();
        set_word(0, '0);
        for (int k = 1; k < FL; k++) step();
        check("parity_7", 64'(serial_out), 64'd1);
        set_word(0, 28'h0000003);
        step();
        set_word(0, '0);
        for (int k = 1; k < FL; k++) step();
        check("parity_3", 64'(serial_out), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
